// File: rtl/clock_pkg.sv
// Shared alarm/clock definitions: alarm state encoding, BCD digit width, default clock rate.
package clock_pkg;

  localparam int BCD_W          = 4;
  localparam int DEFAULT_CLK_HZ = 100_000_000;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// Bundle of time/alarm digits, user controls and ring indicators between the clock logic and alarm_trigger.
interface alarm_trigger_if;
  import clock_pkg::*;

  logic [BCD_W-1:0] time_hourten;
  logic [BCD_W-1:0] time_hour;
  logic [BCD_W-1:0] time_minten;
  logic [BCD_W-1:0] time_min;
  logic [BCD_W-1:0] alarm_hourten;
  logic [BCD_W-1:0] alarm_hour;
  logic [BCD_W-1:0] alarm_minten;
  logic [BCD_W-1:0] alarm_min;
  logic             alarm_mode;
  logic             alarm_enable;
  logic             sec_tick;
  logic             dismiss;
  logic             snooze;
  logic             armed;
  logic             ringing;
  logic             snooze_active;
  logic             buzzer;
  logic             alarm_led;

  modport master (
    output time_hourten, time_hour, time_minten, time_min,
    output alarm_hourten, alarm_hour, alarm_minten, alarm_min,
    output alarm_mode, alarm_enable, sec_tick, dismiss, snooze,
    input  armed, ringing, snooze_active, buzzer, alarm_led
  );

  modport slave (
    input  time_hourten, time_hour, time_minten, time_min,
    input  alarm_hourten, alarm_hour, alarm_minten, alarm_min,
    input  alarm_mode, alarm_enable, sec_tick, dismiss, snooze,
    output armed, ringing, snooze_active, buzzer, alarm_led
  );

endinterface

// File: rtl/tone_gen.sv
// Free-running buzzer square wave; toggles every CLK_HZ/(2*TONE_HZ) clocks.
module tone_gen
  import clock_pkg::*;
#(
  parameter int CLK_HZ  = DEFAULT_CLK_HZ,
  parameter int TONE_HZ = 2000
) (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  output logic tone
);

  localparam int HALF   = CLK_HZ / (2 * TONE_HZ);
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

  logic [HALF_W-1:0] half_cnt_r;
  logic              tone_r;

  // Half-period counter and toggle flop
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      half_cnt_r <= {HALF_W{1'b0}};
      tone_r     <= 1'b0;
    end else if (half_cnt_r == HALF_LAST) begin
      half_cnt_r <= {HALF_W{1'b0}};
      tone_r     <= ~tone_r;
    end else begin
      half_cnt_r <= half_cnt_r + HALF_W'(1);
      tone_r     <= tone_r;
    end
  end

  assign tone = tone_r;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm ring controller: rings on the start of a matching minute until dismissed, snoozed or timed out.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_trigger
  import clock_pkg::*;
#(
  parameter int CLK_HZ         = DEFAULT_CLK_HZ,
  parameter int TONE_HZ        = 2000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300
) (
  input logic      CLK100MHZ,
  input logic      CPU_RESETN,
  alarm_trigger_if.slave bus
);

`ifdef ALARM_SNOOZE_EN
  localparam int CNT_MAX = max_int(RING_TIMEOUT_S, SNOOZE_S);
`else
  localparam int CNT_MAX = RING_TIMEOUT_S;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_TIMEOUT_S - 1);

  state_e           state_r;
  state_e           state_next_s;
  logic             match_s;
  logic             match_q_r;
  logic             match_rise_r;
  logic             dismiss_q_r;
  logic             dismiss_rise_s;
  logic             snooze_rise_s;
  logic [CNT_W-1:0] sec_cnt_r;
  logic             cadence_r;
  logic             tone_s;

  assign match_s = (bus.time_hourten == bus.alarm_hourten) &&
                   (bus.time_hour    == bus.alarm_hour)    &&
                   (bus.time_minten  == bus.alarm_minten)  &&
                   (bus.time_min     == bus.alarm_min);

  // match_q resets high so a time already equal to the alarm never looks like a fresh edge
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      match_q_r    <= 1'b1;
      match_rise_r <= 1'b0;
      dismiss_q_r  <= 1'b1;
    end else begin
      match_q_r    <= match_s;
      match_rise_r <= match_s & ~match_q_r & ~bus.alarm_mode;
      dismiss_q_r  <= bus.dismiss;
    end
  end

  assign dismiss_rise_s = bus.dismiss & ~dismiss_q_r;

`ifdef ALARM_SNOOZE_EN
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);
  logic snooze_q_r;

  // Snooze button edge register
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      snooze_q_r <= 1'b1;
    end else begin
      snooze_q_r <= bus.snooze;
    end
  end

  assign snooze_rise_s = bus.snooze & ~snooze_q_r;
`else
  logic unused_snooze_s;
  assign unused_snooze_s = bus.snooze ^ (SNOOZE_S < 0);
  assign snooze_rise_s   = 1'b0;
`endif

  // Next-state logic; disable beats dismiss beats snooze beats the seconds timeout
  always_comb begin
    state_next_s = state_r;
    if (!bus.alarm_enable) begin
      state_next_s = DISARMED;
    end else begin
      case (state_r)
        DISARMED: state_next_s = ARMED;
        ARMED: begin
          if (match_rise_r) begin
            state_next_s = RINGING;
          end else begin
            state_next_s = ARMED;
          end
        end
        RINGING: begin
          if (dismiss_rise_s) begin
            state_next_s = ARMED;
          end else if (snooze_rise_s) begin
            state_next_s = SNOOZE;
          end else if (bus.sec_tick && (sec_cnt_r == RING_LAST)) begin
            state_next_s = ARMED;
          end else begin
            state_next_s = RINGING;
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (dismiss_rise_s) begin
            state_next_s = ARMED;
          end else if (bus.sec_tick && (sec_cnt_r == SNOOZE_LAST)) begin
            state_next_s = RINGING;
          end else begin
            state_next_s = SNOOZE;
          end
        end
`endif
        default: state_next_s = DISARMED;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_r <= DISARMED;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Seconds counter and LED cadence restart on every state entry
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sec_cnt_r <= {CNT_W{1'b0}};
      cadence_r <= 1'b0;
    end else if (state_next_s != state_r) begin
      sec_cnt_r <= {CNT_W{1'b0}};
      cadence_r <= 1'b0;
    end else if (bus.sec_tick) begin
      sec_cnt_r <= sec_cnt_r + CNT_W'(1);
      cadence_r <= (state_r == RINGING) ? ~cadence_r : cadence_r;
    end else begin
      sec_cnt_r <= sec_cnt_r;
      cadence_r <= cadence_r;
    end
  end

  tone_gen #(
    .CLK_HZ  (CLK_HZ),
    .TONE_HZ (TONE_HZ)
  ) u_tone_gen (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .tone       (tone_s)
  );

  // Outputs decode only flops, so reset clears them without a clock edge
  assign bus.armed     = (state_r != DISARMED);
  assign bus.ringing   = (state_r == RINGING);
  assign bus.alarm_led = bus.ringing & cadence_r;
  assign bus.buzzer    = bus.ringing & ~cadence_r & tone_s;
`ifdef ALARM_SNOOZE_EN
  assign bus.snooze_active = (state_r == SNOOZE);
`else
  assign bus.snooze_active = 1'b0;
`endif

endmodule
